// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared constants for the dmem arbiter: data width,
// grant encodings and the default DMA burst limit.
package riscv_dmem_arbiter_pkg;

    localparam int XLEN = 32;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DMA = 1'b1;

    localparam int MAX_BURST_DEF = 4;
    localparam int BCNT_W_DEF    = 4;

endpackage

// File: rtl/riscv_dmem_arbiter_if.sv
// Bus bundle between CPU/DMA requesters, arbiter and dmem.
// slave: arbiter view; master: requester + memory view.
interface riscv_dmem_arbiter_if;
    import riscv_dmem_arbiter_pkg::*;

    logic            cpu_req;
    logic [XLEN-1:0] cpu_addr;
    logic            cpu_wr_en;
    logic [3:0]      cpu_byte_sel;
    logic [XLEN-1:0] cpu_wr_data;
    logic            cpu_ack;
    logic            cpu_stall;

    logic            dma_req;
    logic            dma_lock;
    logic [XLEN-1:0] dma_addr;
    logic            dma_wr_en;
    logic [3:0]      dma_byte_sel;
    logic [XLEN-1:0] dma_wr_data;
    logic            dma_ack;

    logic [XLEN-1:0] rd_data;

    logic [XLEN-1:0] dmem_addr;
    logic            dmem_wr_en;
    logic [3:0]      dmem_byte_sel;
    logic [XLEN-1:0] dmem_wr_data;
    logic [XLEN-1:0] dmem_rd_data;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wr_en,
        input  cpu_byte_sel, cpu_wr_data,
        output cpu_ack, cpu_stall,
        input  dma_req, dma_lock, dma_addr,
        input  dma_wr_en, dma_byte_sel,
        input  dma_wr_data,
        output dma_ack,
        output rd_data,
        output dmem_addr, dmem_wr_en,
        output dmem_byte_sel, dmem_wr_data,
        input  dmem_rd_data
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wr_en,
        output cpu_byte_sel, cpu_wr_data,
        input  cpu_ack, cpu_stall,
        output dma_req, dma_lock, dma_addr,
        output dma_wr_en, dma_byte_sel,
        output dma_wr_data,
        input  dma_ack,
        input  rd_data,
        input  dmem_addr, dmem_wr_en,
        input  dmem_byte_sel, dmem_wr_data,
        output dmem_rd_data
    );

endinterface

// File: rtl/riscv_dmem_arbiter_rr_arb2.sv
// riscv_rr_arb2: two-request round-robin with a bounded DMA lock.
// Ports: i_clk, i_rstn, cpu_req, dma_req, dma_lock -> gnt (one-hot).
module riscv_rr_arb2
    import riscv_dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int BCNT_W    = BCNT_W_DEF
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic       dma_lock,
    output logic [1:0] gnt
);

    localparam logic [BCNT_W-1:0] MAX_B =
        BCNT_W'(MAX_BURST);

    logic              r_last;
    logic [BCNT_W-1:0] r_bcnt;
    logic              locked;

    // Grants are gated by reset so acks drop the
    // moment reset asserts, not at the next edge.
    always_comb begin
        gnt    = '0;
        locked = dma_lock
               && (r_last == GNT_DMA)
               && (r_bcnt < MAX_B);
        if (i_rstn) begin
            unique case ({cpu_req, dma_req})
                2'b10: gnt[GNT_CPU] = 1'b1;
                2'b01: gnt[GNT_DMA] = 1'b1;
                2'b11: begin
                    if (locked || r_last == GNT_CPU)
                        gnt[GNT_DMA] = 1'b1;
                    else
                        gnt[GNT_CPU] = 1'b1;
                end
                default: gnt = '0;
            endcase
        end
    end

    // r_last resets to DMA so the CPU wins the first tie.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_last <= GNT_DMA;
            r_bcnt <= '0;
        end else if (gnt[GNT_DMA]) begin
            r_last <= GNT_DMA;
            r_bcnt <= (r_bcnt < MAX_B)
                    ? r_bcnt + 1'b1 : MAX_B;
        end else if (gnt[GNT_CPU]) begin
            r_last <= GNT_CPU;
            r_bcnt <= '0;
        end else begin
            r_bcnt <= '0;
        end
    end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Shares the single-port dmem between CPU (port 0) and DMA (port 1).
// Ports: i_clk, i_rstn, bus (slave: requesters, acks, stall, dmem side).
module riscv_dmem_arbiter
    import riscv_dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int BCNT_W    = BCNT_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    riscv_dmem_arbiter_if.slave  bus
);

    logic [1:0] gnt;

    riscv_rr_arb2 #(
        .MAX_BURST (MAX_BURST),
        .BCNT_W    (BCNT_W)
    ) u_arb (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .cpu_req  (bus.cpu_req),
        .dma_req  (bus.dma_req),
        .dma_lock (bus.dma_lock),
        .gnt      (gnt)
    );

    // Ungranted fields never reach dmem; idle bus is all zero.
    always_comb begin
        bus.dmem_addr     = '0;
        bus.dmem_wr_en    = 1'b0;
        bus.dmem_byte_sel = '0;
        bus.dmem_wr_data  = '0;
        if (gnt[GNT_CPU]) begin
            bus.dmem_addr     = bus.cpu_addr;
            bus.dmem_wr_en    = bus.cpu_wr_en;
            bus.dmem_byte_sel = bus.cpu_byte_sel;
            bus.dmem_wr_data  = bus.cpu_wr_data;
        end else if (gnt[GNT_DMA]) begin
            bus.dmem_addr     = bus.dma_addr;
            bus.dmem_wr_en    = bus.dma_wr_en;
            bus.dmem_byte_sel = bus.dma_byte_sel;
            bus.dmem_wr_data  = bus.dma_wr_data;
        end
    end

    assign bus.cpu_ack   = gnt[GNT_CPU];
    assign bus.dma_ack   = gnt[GNT_DMA];
    assign bus.cpu_stall = bus.cpu_req & ~gnt[GNT_CPU];
    assign bus.rd_data   = bus.dmem_rd_data;

endmodule

// File: doc/riscv_dmem_arbiter.md
Name: riscv_dmem_arbiter

Overview:
- Shares the single-port riscv_dmem between two requesters: port 0 is the pipeline CPU data port, port 1 is a DMA/loader master (test loader, future peripheral DMA).
- Sits between riscv_pipeline_cpu, the loader and riscv_dmem inside riscv_top.
- Round-robin arbitration, with an optional DMA lock for bursts; the lock is bounded by MAX_BURST so the CPU cannot starve.
- Produces a CPU stall when the CPU loses arbitration.

Parameters:
- MAX_BURST, 4: maximum consecutive locked DMA grants while the CPU is requesting; legal range 1..15.
- BCNT_W, 4: burst counter width; must satisfy 2^BCNT_W > MAX_BURST.

Ports:
- i_clk  input  1  clock; all state on rising edge
- i_rstn  input  1  asynchronous active-low reset
- i_cpu_req  input  1  CPU access request, level, held until acked
- i_cpu_addr  input  `XLEN  CPU byte address
- i_cpu_wr_en  input  1  CPU write
- i_cpu_byte_sel  input  4  CPU byte lanes
- i_cpu_wr_data  input  `XLEN  CPU write data
- o_cpu_ack  output  1  CPU access performed this cycle
- o_cpu_stall  output  1  i_cpu_req & ~o_cpu_ack; freezes the pipeline
- i_dma_req  input  1  DMA request, level, held until acked
- i_dma_lock  input  1  DMA requests burst priority
- i_dma_addr  input  `XLEN  DMA byte address
- i_dma_wr_en  input  1  DMA write
- i_dma_byte_sel  input  4  DMA byte lanes
- i_dma_wr_data  input  `XLEN  DMA write data
- o_dma_ack  output  1  DMA access performed this cycle
- o_rd_data  output  `XLEN  dmem read data, broadcast; valid only with the matching ack
- o_dmem_addr  output  `XLEN  to riscv_dmem
- o_dmem_wr_en  output  1  to riscv_dmem
- o_dmem_byte_sel  output  4  to riscv_dmem
- o_dmem_wr_data  output  `XLEN  to riscv_dmem
- i_dmem_rd_data  input  `XLEN  from riscv_dmem (combinational read)

Behaviour:
- State:
  - r_last: last served port, 0 = CPU, 1 = DMA.
  - r_bcnt: count of consecutive DMA grants, BCNT_W bits.
- Reset (async, i_rstn low):
  - r_last = 1, so the CPU wins the first tie.
  - r_bcnt = 0.
  - o_cpu_ack = o_dma_ack = 0, o_dmem_wr_en = 0, o_dmem_addr = 0.
  - o_cpu_stall = i_cpu_req.
  - Reset mid-burst drops the lock; no partial write is possible because the write commits only on a clock edge.
- Grant decision is combinational in the current cycle:
  - No requests: no grant; o_dmem_wr_en = 0, o_dmem_addr/byte_sel/wr_data = 0.
  - One requester: that requester is granted.
  - Both, locked (i_dma_lock & r_last = 1 & r_bcnt < MAX_BURST): DMA granted.
  - Both, otherwise: grant the port != r_last (round-robin).
- Latency: zero-cycle ack.
  - Read: ack and o_rd_data are valid in the grant cycle.
  - Write: commits at the rising edge ending the grant cycle.
  - A requester that sees its ack may change or drop its request next cycle.
- o_dmem_* is a pure mux of the granted port's fields; o_rd_data = i_dmem_rd_data.
- Update at each clock edge when a grant occurs:
  - r_last = granted port.
  - r_bcnt = DMA granted ? saturate(r_bcnt + 1) : 0.
  - No grant: r_bcnt = 0, r_last unchanged.
- Starvation bound: with both requesting and the lock held, the CPU is served within MAX_BURST + 1 cycles.
- Lock with the CPU idle: the DMA is served every cycle.
  - r_bcnt saturates at MAX_BURST and keeps holding it while the DMA continues.
  - If the CPU then requests, it wins the next tie.
- The arbiter ignores address overlap; ordering between ports is grant order.
- No X propagation: fields of an unrequested port never reach o_dmem_*.

Decomposition:
- Shared defines header (already provides `XLEN, `DMEM_ADDR_BIT):
  - add grant encodings GNT_CPU = 0, GNT_DMA = 1
  - add the default MAX_BURST.
- One natural sub-module: riscv_rr_arb2.
  - Two-request round-robin with lock qualifier.
  - Holds r_last/r_bcnt, outputs a one-hot grant.
- The top level contains only the data muxes and stall logic.

Test Plan:
- Reset then CPU-only stream:
  - Stimulus: write 0xDEADBEEF to 0x10 (byte_sel 4'hF), then read 0x10.
  - Required: o_cpu_ack every cycle, o_cpu_stall = 0, read returns 0xDEADBEEF.
- Simultaneous request on the first cycle after reset, no lock:
  - Required: CPU granted first, then DMA, then CPU, alternating.
  - Each loser's stall/ack is low for exactly one cycle.
- DMA locked burst of 8 writes (0x100..0x11C) with the CPU requesting throughout, MAX_BURST = 4:
  - Required grant order: DMA×4, CPU×1, DMA×4 …
  - All eight words read back correctly.
- Byte-lane write:
  - Stimulus: DMA writes 0x000000AB with byte_sel 4'b0001 to 0x20 (preloaded 0x11223344); CPU then reads.
  - Required: 0x112233AB.
- Async reset asserted mid-lock burst:
  - Required: acks drop immediately and o_dmem_wr_en = 0.
  - After release, a tie goes to the CPU and r_bcnt restarts at 0.
